// File: rtl/move_exec.sv
// move_exec: executes decoded MOV/MOVL/MOVH/SWAP commands against a register file
// through one registered read port and one write port.
module move_exec #(
  parameter int WIDTH       = 32,
  parameter int REGS_CODING = 3,
  parameter int FLAGS       = 4,
  parameter int ZERO        = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   move_en,
  input  logic [WIDTH/2-1:0]     immediate,
  input  logic [1:0]             mode,
  input  logic [REGS_CODING-1:0] op1,
  input  logic [REGS_CODING-1:0] op2,
  input  logic                   suffix,
  input  logic [FLAGS-1:0]       flags,
  output logic                   busy,
  output logic                   done,
  output logic                   skipped,
  output logic [REGS_CODING-1:0] rf_raddr,
  input  logic [WIDTH-1:0]       rf_rdata,
  output logic [REGS_CODING-1:0] rf_waddr,
  output logic [WIDTH-1:0]       rf_wdata,
  output logic                   rf_wren
);
  localparam int H = WIDTH / 2;
  typedef enum logic [2:0] {IDLE, RD_A, CAP_A, CAP_B, WR_A, WR_B, DONE} state_t;
  state_t state_q, state_d;
  logic [H-1:0] imm_q, imm_d;
  logic [1:0] mode_q, mode_d;
  logic [REGS_CODING-1:0] op1_q, op1_d, op2_q, op2_d;
  logic sfx_q, sfx_d, cond_q, cond_d;
  logic [WIDTH-1:0] tmp_a_q, tmp_a_d, tmp_b_q, tmp_b_d;
  logic swap;
  logic unused_flags;
  assign unused_flags = ^flags;
  assign swap = mode_q == 2'd3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      imm_q   <= '0;
      mode_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      sfx_q   <= 1'b0;
      cond_q  <= 1'b0;
      tmp_a_q <= '0;
      tmp_b_q <= '0;
    end else begin
      state_q <= state_d;
      imm_q   <= imm_d;
      mode_q  <= mode_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sfx_q   <= sfx_d;
      cond_q  <= cond_d;
      tmp_a_q <= tmp_a_d;
      tmp_b_q <= tmp_b_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    imm_d    = imm_q;
    mode_d   = mode_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    sfx_d    = sfx_q;
    cond_d   = cond_q;
    tmp_a_d  = tmp_a_q;
    tmp_b_d  = tmp_b_q;
    busy     = state_q != IDLE;
    done     = 1'b0;
    skipped  = 1'b0;
    rf_raddr = '0;
    rf_waddr = '0;
    rf_wdata = '0;
    rf_wren  = 1'b0;
    case (state_q)
      IDLE: if (move_en) begin
        imm_d   = immediate;
        mode_d  = mode;
        op1_d   = op1;
        op2_d   = op2;
        sfx_d   = suffix;
        cond_d  = !suffix | flags[ZERO];
        state_d = cond_d ? RD_A : DONE;
      end
      RD_A: begin
        rf_raddr = mode_q == 2'd0 ? op2_q : op1_q;
        state_d  = CAP_A;
      end
      CAP_A: begin
        tmp_a_d  = rf_rdata;
        rf_raddr = swap ? op2_q : '0;
        state_d  = swap ? CAP_B : WR_A;
      end
      CAP_B: begin
        tmp_b_d = rf_rdata;
        state_d = WR_A;
      end
      WR_A: begin
        rf_wren  = 1'b1;
        rf_waddr = op1_q;
        rf_wdata = mode_q == 2'd0 ? tmp_a_q :
                   mode_q == 2'd1 ? {tmp_a_q[WIDTH-1:H], imm_q} :
                   mode_q == 2'd2 ? {imm_q, tmp_a_q[H-1:0]} : tmp_b_q;
        state_d  = swap ? WR_B : DONE;
      end
      WR_B: begin
        rf_wren  = 1'b1;
        rf_waddr = op2_q;
        rf_wdata = tmp_a_q;
        state_d  = DONE;
      end
      DONE: begin
        done    = 1'b1;
        skipped = !cond_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_move_exec.sv
// tb_move_exec: directed checks of move_exec against a small registered-read register file.
module tb_move_exec;
  logic clk = 0, rst_n = 0, move_en = 0, suffix = 0;
  logic [15:0] immediate = '0;
  logic [1:0] mode = '0;
  logic [2:0] op1 = '0, op2 = '0, rf_raddr, rf_waddr;
  logic [3:0] flags = '0;
  logic busy, done, skipped, rf_wren;
  logic [31:0] rf_rdata = '0, rf_wdata;
  logic [31:0] regs [8];
  int wr_cnt = 0, n_chk = 0, n_fail = 0, w0;

  move_exec dut (
    .clk(clk), .rst_n(rst_n), .move_en(move_en), .immediate(immediate), .mode(mode),
    .op1(op1), .op2(op2), .suffix(suffix), .flags(flags), .busy(busy), .done(done),
    .skipped(skipped), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_wren(rf_wren)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rf_rdata <= regs[rf_raddr];
    if (rf_wren) begin
      regs[rf_waddr] <= rf_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] m, input logic [2:0] a, input logic [2:0] b,
                     input logic [15:0] imm, input logic s, input logic [3:0] f);
    mode = m; op1 = a; op2 = b; immediate = imm; suffix = s; flags = f; move_en = 1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = '0;
    tick; tick;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_skip", skipped, 0);
    chk("rst_wren", rf_wren, 0); chk("rst_raddr", rf_raddr, 0);
    chk("rst_waddr", rf_waddr, 0); chk("rst_wdata", rf_wdata, 0);
    rst_n = 1;
    regs[2] = 32'hDEADBEEF;
    regs[1] = 32'h12345678;
    tick;
    // MOV R5 <- R2
    cmd(0, 5, 2, 0, 0, 0);
    tick; move_en = 0;
    chk("mov_raddr", rf_raddr, 2); chk("mov_busy1", busy, 1); chk("mov_nodone", done, 0);
    tick; chk("mov_nowren2", rf_wren, 0);
    tick; chk("mov_wren", rf_wren, 1); chk("mov_waddr", rf_waddr, 5);
    chk("mov_wdata", rf_wdata, 32'hDEADBEEF);
    tick; chk("mov_done", done, 1); chk("mov_skip", skipped, 0); chk("mov_wren4", rf_wren, 0);
    chk("mov_busy4", busy, 1);
    tick; chk("mov_idle", busy, 0); chk("mov_r5", regs[5], 32'hDEADBEEF);
    // MOVL then MOVH on R1
    cmd(1, 1, 0, 16'hABCD, 0, 0);
    tick; move_en = 0; chk("movl_raddr", rf_raddr, 1);
    tick; tick; chk("movl_wdata", rf_wdata, 32'h1234ABCD); chk("movl_waddr", rf_waddr, 1);
    tick; chk("movl_done", done, 1);
    tick;
    cmd(2, 1, 0, 16'h0F0F, 0, 0);
    tick; move_en = 0;
    tick; tick; chk("movh_wdata", rf_wdata, 32'h0F0FABCD); chk("movh_wren", rf_wren, 1);
    tick; chk("movh_done", done, 1);
    tick; chk("movh_r1", regs[1], 32'h0F0FABCD);
    // SWAP R3 <-> R4
    regs[3] = 32'h11111111; regs[4] = 32'h22222222;
    cmd(3, 3, 4, 0, 0, 0);
    tick; move_en = 0; chk("swp_raddr1", rf_raddr, 3); chk("swp_busy1", busy, 1);
    tick; chk("swp_raddr2", rf_raddr, 4);
    tick; chk("swp_nowren3", rf_wren, 0); chk("swp_busy3", busy, 1);
    tick; chk("swp_wrA", {rf_wren, 2'b0, rf_waddr}, 6'h23); chk("swp_dA", rf_wdata, 32'h22222222);
    tick; chk("swp_wrB", {rf_wren, 2'b0, rf_waddr}, 6'h24); chk("swp_dB", rf_wdata, 32'h11111111);
    tick; chk("swp_done", done, 1); chk("swp_busy6", busy, 1); chk("swp_wren6", rf_wren, 0);
    tick; chk("swp_idle", busy, 0);
    chk("swp_r3", regs[3], 32'h22222222); chk("swp_r4", regs[4], 32'h11111111);
    // conditional: Z clear skips, Z set executes
    w0 = wr_cnt;
    cmd(0, 6, 2, 0, 1, 4'b0000);
    tick; move_en = 0; chk("skp_done", done, 1); chk("skp_skip", skipped, 1);
    chk("skp_wren", rf_wren, 0);
    tick; chk("skp_idle", busy, 0); chk("skp_nowrite", wr_cnt, w0); chk("skp_r6", regs[6], 0);
    cmd(0, 6, 2, 0, 1, 4'b1000);
    tick; move_en = 0; flags = 4'b0000; chk("cnd_raddr", rf_raddr, 2);
    tick; tick; chk("cnd_wrA", {rf_wren, 2'b0, rf_waddr}, 6'h26);
    chk("cnd_wdata", rf_wdata, 32'hDEADBEEF);
    tick; chk("cnd_done", done, 1); chk("cnd_skip", skipped, 0);
    tick;
    // back-to-back: move_en held high, fields change while busy
    cmd(0, 7, 1, 0, 0, 0);
    tick; w0 = wr_cnt; chk("b2b_raddr", rf_raddr, 1);
    op1 = 0; op2 = 5;
    tick; tick; chk("b2b_waddr", rf_waddr, 7); chk("b2b_wdata", rf_wdata, 32'h0F0FABCD);
    tick; chk("b2b_done", done, 1);
    tick; chk("b2b_idle", busy, 0); chk("b2b_one_wr", wr_cnt, w0 + 1);
    tick; move_en = 0; chk("b2b_busy2", busy, 1); chk("b2b_raddr2", rf_raddr, 5);
    tick; tick; chk("b2b_wr2", {rf_wren, 2'b0, rf_waddr}, 6'h20);
    chk("b2b_wdata2", rf_wdata, 32'hDEADBEEF);
    tick; chk("b2b_done2", done, 1);
    tick; chk("b2b_r7", regs[7], 32'h0F0FABCD);
    // reset in WR_B of a SWAP
    regs[3] = 32'h33333333; regs[4] = 32'h44444444;
    cmd(3, 3, 4, 0, 0, 0);
    tick; move_en = 0;
    tick; tick; tick; chk("rsw_wrA", rf_wdata, 32'h44444444);
    tick; chk("rsw_inWRB", rf_wren, 1);
    rst_n = 0; #1;
    chk("rsw_busy", busy, 0); chk("rsw_wren", rf_wren, 0); chk("rsw_waddr", rf_waddr, 0);
    chk("rsw_wdata", rf_wdata, 0); chk("rsw_done", done, 0);
    tick; tick; rst_n = 1;
    chk("rsw_r3", regs[3], 32'h44444444); chk("rsw_r4", regs[4], 32'h44444444);
    tick;
    cmd(0, 2, 3, 0, 0, 0);
    tick; move_en = 0; chk("rsw_mov_raddr", rf_raddr, 3);
    tick; tick; chk("rsw_mov_wr", {rf_wren, 2'b0, rf_waddr}, 6'h22);
    chk("rsw_mov_wdata", rf_wdata, 32'h44444444);
    tick; chk("rsw_mov_done", done, 1);
    tick;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/move_exec.md
Name: move_exec

Overview:
- Execution end of the move-control path: accepts the move command the decoder issues (move_en, immediate, mode, op1, op2, suffix) and carries it out against the register file.
- Performs register copy, half-word immediate loads, and register swap through one registered read port and one write port.
- Reports busy/done/skipped to the issue logic.

Parameters:
- WIDTH, 32, register width; immediate is WIDTH/2.
- REGS_CODING, 3, register address width.
- FLAGS, 4, flag vector width.
- ZERO, 3, index of the zero flag in flags.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- move_en  in  1  command valid; single-cycle strobe from the decoder.
- immediate  in  WIDTH/2  immediate for MOVL/MOVH.
- mode  in  2  0=MOV, 1=MOVL, 2=MOVH, 3=SWAP.
- op1  in  REGS_CODING  destination register (first operand for SWAP).
- op2  in  REGS_CODING  source register (second operand for SWAP).
- suffix  in  1  1 = execute only if flags[ZERO]=1.
- flags  in  FLAGS  current ALU flags, sampled at accept.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle completion pulse.
- skipped  out  1  valid with done; 1 = condition failed, no write.
- rf_raddr  out  REGS_CODING  register file read address.
- rf_rdata  in  WIDTH  read data; registered, valid the cycle after rf_raddr.
- rf_waddr  out  REGS_CODING  write address.
- rf_wdata  out  WIDTH  write data.
- rf_wren  out  1  write enable, one cycle per write.

Behaviour:
- Reset state: IDLE. busy, done, skipped, rf_wren = 0; rf_raddr, rf_waddr, rf_wdata = 0; internal latches = 0.
- FSM states: IDLE, RD_A, CAP_A, CAP_B, WR_A, WR_B, DONE.
- Accept: in IDLE with move_en=1 at edge N, latch immediate, mode, op1, op2, suffix, and cond = !suffix | flags[ZERO].
  - If cond=1, go to RD_A.
  - If cond=0, go to DONE with skipped=1. done is high in cycle N+1 and no rf_wren is issued.
- Ignored strobes: move_en outside IDLE is ignored, with no queuing. The decoder must hold off while busy.
- RD_A (N+1): rf_raddr = op2 for MOV, op1 otherwise. Next state is CAP_A.
- CAP_A (N+2): capture rf_rdata into tmp_a.
  - For SWAP: rf_raddr = op2, next state CAP_B.
  - Otherwise: next state WR_A.
- CAP_B (N+3, SWAP only): capture rf_rdata into tmp_b. Next state WR_A.
- WR_A: rf_wren=1, rf_waddr=op1. rf_wdata depends on mode:
  - MOV: tmp_a.
  - MOVL: {tmp_a[WIDTH-1:WIDTH/2], immediate}.
  - MOVH: {immediate, tmp_a[WIDTH/2-1:0]}.
  - SWAP: tmp_b.
  - Next state is WR_B for SWAP, DONE otherwise.
- WR_B (SWAP only): rf_wren=1, rf_waddr=op2, rf_wdata=tmp_a. Next state DONE.
- DONE: done=1 for one cycle, then IDLE. A new move_en is accepted on the DONE cycle's following edge, i.e. in IDLE.
- Latency from accept edge N:
  - Executed MOV/MOVL/MOVH: write at N+3, done at N+4.
  - SWAP: writes at N+4 and N+5, done at N+6.
  - Skipped: done at N+1.
- busy timing: busy=1 in every non-IDLE state, including DONE.
- op1==op2:
  - MOV rewrites the same value.
  - SWAP performs both writes with the unchanged value.
  - Both are legal, with no special case.
- Flags: sampled only at accept; later flag changes have no effect.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A SWAP reset after WR_A leaves op1 written and op2 unwritten. This is accepted; the issue logic re-issues.
- rf_wren is never high outside WR_A/WR_B.

Test Plan:
- MOV: R2=0xDEADBEEF; move_en, mode=0, op1=5, op2=2, suffix=0 -> rf_raddr=2 at N+1; rf_wren at N+3 with waddr=5, wdata=0xDEADBEEF; done at N+4, skipped=0.
- MOVL/MOVH: R1=0x12345678; MOVL imm=0xABCD, op1=1 -> wdata=0x1234ABCD. Then MOVH imm=0x0F0F -> wdata=0x0F0FABCD.
- SWAP: R3=0x11111111, R4=0x22222222; mode=3, op1=3, op2=4 -> write R3=0x22222222 at N+4, R4=0x11111111 at N+5; done at N+6; busy high N+1..N+6.
- Conditional: suffix=1 with flags=4'b0000 -> done and skipped at N+1, no rf_wren. Same command with flags=4'b1000 -> executes normally.
- Back-to-back: move_en held high continuously through a MOV -> strobes during busy are ignored; exactly one write; the next command is accepted in the cycle after done.
- Reset: assert rst_n=0 at N+5 of a SWAP -> outputs 0 immediately; R3 updated, R4 unchanged; after release, a MOV executes with normal latency.
